// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage sitting directly in front of the instruction
// memory. Owns the program counter, presents it to the memory as the read
// address, and captures the returned word into the IF/ID pipeline register.
// Handles sequential/redirect next-PC selection, hazard stall, flush
// squashing, fetch-range checking and a saturating fetched-instruction count.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   stall          hold PC and IF/ID
//   flush          squash the IF/ID slot (bubble)
//   redirect_valid taken branch/jump from a later stage
//   redirect_pc    redirect target (low two bits flag a misalignment)
//   imem_pc        instruction memory byte address (= PC register)
//   imem_instr     combinational instruction word for imem_pc
//   ifid_valid     IF/ID holds a real instruction
//   ifid_pc        PC of the IF/ID instruction
//   ifid_pc_plus4  ifid_pc + 4
//   ifid_instr     captured instruction word
//   fetch_err      sticky misaligned-redirect / out-of-range flag
//   fetch_count    saturating count of valid IF/ID writes
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC   = 32'(IMEM_BYTES - 4);
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // Registered state
    logic [31:0] pcReg;
    logic        ifidValidReg;
    logic [31:0] ifidPcReg;
    logic [31:0] ifidPcPlus4Reg;
    logic [31:0] ifidInstrReg;
    logic        fetchErrReg;
    logic [31:0] fetchCountReg;

    // Next-state values
    logic [31:0] pcNext;
    logic        ifidValidNext;
    logic [31:0] ifidPcNext;
    logic [31:0] ifidPcPlus4Next;
    logic [31:0] ifidInstrNext;
    logic        fetchErrNext;
    logic [31:0] fetchCountNext;

    logic        rangeOk;
    logic        misalignedRedirect;
    logic [31:0] pcPlus4;

    assign rangeOk            = (pcReg <= LAST_PC) && (pcReg[1:0] == 2'b00);
    assign misalignedRedirect = (redirect_pc[1:0] != 2'b00);
    assign pcPlus4            = pcReg + 32'd4;

    // Priority: redirect > stall > normal fetch.
    always_comb begin
        pcNext          = pcReg;
        ifidValidNext   = ifidValidReg;
        ifidPcNext      = ifidPcReg;
        ifidPcPlus4Next = ifidPcPlus4Reg;
        ifidInstrNext   = ifidInstrReg;
        fetchErrNext    = fetchErrReg;
        fetchCountNext  = fetchCountReg;

        if (redirect_valid) begin
            // The word at the old PC is on the wrong path: drop it, leave
            // the IF/ID data fields as they were.
            pcNext        = {redirect_pc[31:2], 2'b00};
            ifidValidNext = 1'b0;
            if (misalignedRedirect) begin
                fetchErrNext = 1'b1;
            end
        end else if (stall) begin
            if (flush) begin
                ifidValidNext = 1'b0;
            end
        end else if (rangeOk) begin
            ifidPcNext      = pcReg;
            ifidPcPlus4Next = pcPlus4;
            ifidInstrNext   = imem_instr;
            ifidValidNext   = ~flush;
            pcNext          = pcPlus4;
            if (!flush && (fetchCountReg != COUNT_MAX)) begin
                fetchCountNext = fetchCountReg + 32'd1;
            end
        end else begin
            // PC left the legal window: stop fetching here and park the PC
            // until a redirect or reset moves it.
            ifidValidNext = 1'b0;
            fetchErrNext  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg          <= RESET_PC;
            ifidValidReg   <= 1'b0;
            ifidPcReg      <= 32'd0;
            ifidPcPlus4Reg <= 32'd0;
            ifidInstrReg   <= 32'd0;
            fetchErrReg    <= 1'b0;
            fetchCountReg  <= 32'd0;
        end else begin
            pcReg          <= pcNext;
            ifidValidReg   <= ifidValidNext;
            ifidPcReg      <= ifidPcNext;
            ifidPcPlus4Reg <= ifidPcPlus4Next;
            ifidInstrReg   <= ifidInstrNext;
            fetchErrReg    <= fetchErrNext;
            fetchCountReg  <= fetchCountNext;
        end
    end

    assign imem_pc       = pcReg;
    assign ifid_valid    = ifidValidReg;
    assign ifid_pc       = ifidPcReg;
    assign ifid_pc_plus4 = ifidPcPlus4Reg;
    assign ifid_instr    = ifidInstrReg;
    assign fetch_err     = fetchErrReg;
    assign fetch_count   = fetchCountReg;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A small combinational memory model returns
// word (i+1)*0x11 at byte address 4*i, so 0x11/0x22/0x33 sit at 0/4/8.
// Inputs are changed and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic [31:0] imemPc;
    logic [31:0] imemInstr;
    logic        ifidValid;
    logic [31:0] ifidPc;
    logic [31:0] ifidPcPlus4;
    logic [31:0] ifidInstr;
    logic        fetchErr;
    logic [31:0] fetchCount;

    int nVec;
    int nMis;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (256)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .imem_pc        (imemPc),
        .imem_instr     (imemInstr),
        .ifid_valid     (ifidValid),
        .ifid_pc        (ifidPc),
        .ifid_pc_plus4  (ifidPcPlus4),
        .ifid_instr     (ifidInstr),
        .fetch_err      (fetchErr),
        .fetch_count    (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word index i holds (i+1)*0x11; outside memory reads junk.
    always_comb begin
        if (imemPc < 32'd256) begin
            imemInstr = (32'(imemPc[7:2]) + 32'd1) * 32'h11;
        end else begin
            imemInstr = 32'hDEAD_BEEF;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst           = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        nVec++; if (imemPc !== 32'h0) begin nMis++; $display("FAIL reset_pc: got %h want %h", imemPc, 32'h0); end
        nVec++; if (ifidValid !== 1'b0) begin nMis++; $display("FAIL reset_valid: got %b want 0", ifidValid); end
        nVec++; if (ifidPc !== 32'h0) begin nMis++; $display("FAIL reset_ifid_pc: got %h want 0", ifidPc); end
        nVec++; if (ifidPcPlus4 !== 32'h0) begin nMis++; $display("FAIL reset_plus4: got %h want 0", ifidPcPlus4); end
        nVec++; if (ifidInstr !== 32'h0) begin nMis++; $display("FAIL reset_instr: got %h want 0", ifidInstr); end
        nVec++; if (fetchErr !== 1'b0) begin nMis++; $display("FAIL reset_err: got %b want 0", fetchErr); end
        nVec++; if (fetchCount !== 32'd0) begin nMis++; $display("FAIL reset_count: got %0d want 0", fetchCount); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        step();
        nVec++; if (ifidPc !== 32'h0) begin nMis++; $display("FAIL seq1_ifid_pc: got %h want 0", ifidPc); end
        nVec++; if (ifidPcPlus4 !== 32'h4) begin nMis++; $display("FAIL seq1_plus4: got %h want 4", ifidPcPlus4); end
        nVec++; if (ifidInstr !== 32'h11) begin nMis++; $display("FAIL seq1_instr: got %h want 11", ifidInstr); end
        nVec++; if (ifidValid !== 1'b1) begin nMis++; $display("FAIL seq1_valid: got %b want 1", ifidValid); end
        nVec++; if (imemPc !== 32'h4) begin nMis++; $display("FAIL seq1_imem_pc: got %h want 4", imemPc); end
        nVec++; if (fetchCount !== 32'd1) begin nMis++; $display("FAIL seq1_count: got %0d want 1", fetchCount); end
        step();
        nVec++; if (ifidInstr !== 32'h22) begin nMis++; $display("FAIL seq2_instr: got %h want 22", ifidInstr); end
        nVec++; if (imemPc !== 32'h8) begin nMis++; $display("FAIL seq2_imem_pc: got %h want 8", imemPc); end
        nVec++; if (fetchCount !== 32'd2) begin nMis++; $display("FAIL seq2_count: got %0d want 2", fetchCount); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            nVec++; if (imemPc !== 32'h8) begin nMis++; $display("FAIL stall_imem_pc[%0d]: got %h want 8", i, imemPc); end
            nVec++; if (ifidPc !== 32'h4) begin nMis++; $display("FAIL stall_ifid_pc[%0d]: got %h want 4", i, ifidPc); end
            nVec++; if (ifidInstr !== 32'h22) begin nMis++; $display("FAIL stall_instr[%0d]: got %h want 22", i, ifidInstr); end
            nVec++; if (ifidValid !== 1'b1) begin nMis++; $display("FAIL stall_valid[%0d]: got %b want 1", i, ifidValid); end
            nVec++; if (fetchCount !== 32'd2) begin nMis++; $display("FAIL stall_count[%0d]: got %0d want 2", i, fetchCount); end
        end
        stall = 1'b0;
        step();
        nVec++; if (ifidPc !== 32'h8) begin nMis++; $display("FAIL unstall_ifid_pc: got %h want 8", ifidPc); end
        nVec++; if (ifidInstr !== 32'h33) begin nMis++; $display("FAIL unstall_instr: got %h want 33", ifidInstr); end
        nVec++; if (fetchCount !== 32'd3) begin nMis++; $display("FAIL unstall_count: got %0d want 3", fetchCount); end
        nVec++; if (imemPc !== 32'hC) begin nMis++; $display("FAIL unstall_imem_pc: got %h want c", imemPc); end
    endtask

    task automatic test_redirect_stall_flush();
        redirectValid = 1'b1;
        redirectPc    = 32'h40;
        stall         = 1'b1;
        flush         = 1'b1;
        step();
        clear_inputs();
        nVec++; if (imemPc !== 32'h40) begin nMis++; $display("FAIL redir_imem_pc: got %h want 40", imemPc); end
        nVec++; if (ifidValid !== 1'b0) begin nMis++; $display("FAIL redir_bubble: got %b want 0", ifidValid); end
        nVec++; if (ifidPc !== 32'h8) begin nMis++; $display("FAIL redir_hold_pc: got %h want 8", ifidPc); end
        nVec++; if (fetchCount !== 32'd3) begin nMis++; $display("FAIL redir_count: got %0d want 3", fetchCount); end
        step();
        nVec++; if (ifidPc !== 32'h40) begin nMis++; $display("FAIL redir_tgt_pc: got %h want 40", ifidPc); end
        nVec++; if (ifidValid !== 1'b1) begin nMis++; $display("FAIL redir_tgt_valid: got %b want 1", ifidValid); end
        nVec++; if (ifidInstr !== 32'h121) begin nMis++; $display("FAIL redir_tgt_instr: got %h want 121", ifidInstr); end
        nVec++; if (ifidPcPlus4 !== 32'h44) begin nMis++; $display("FAIL redir_tgt_plus4: got %h want 44", ifidPcPlus4); end
        nVec++; if (fetchErr !== 1'b0) begin nMis++; $display("FAIL redir_err: got %b want 0", fetchErr); end
        nVec++; if (fetchCount !== 32'd4) begin nMis++; $display("FAIL redir_tgt_count: got %0d want 4", fetchCount); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        nVec++; if (ifidValid !== 1'b0) begin nMis++; $display("FAIL flush_valid: got %b want 0", ifidValid); end
        nVec++; if (imemPc !== 32'h48) begin nMis++; $display("FAIL flush_imem_pc: got %h want 48", imemPc); end
        nVec++; if (fetchCount !== 32'd4) begin nMis++; $display("FAIL flush_count: got %0d want 4", fetchCount); end
    endtask

    task automatic test_misaligned();
        redirectValid = 1'b1;
        redirectPc    = 32'h22;
        step();
        clear_inputs();
        nVec++; if (imemPc !== 32'h20) begin nMis++; $display("FAIL misal_imem_pc: got %h want 20", imemPc); end
        nVec++; if (fetchErr !== 1'b1) begin nMis++; $display("FAIL misal_err: got %b want 1", fetchErr); end
        step();
        step();
        nVec++; if (ifidPc !== 32'h24) begin nMis++; $display("FAIL misal_run_pc: got %h want 24", ifidPc); end
        nVec++; if (ifidValid !== 1'b1) begin nMis++; $display("FAIL misal_run_valid: got %b want 1", ifidValid); end
        nVec++; if (fetchErr !== 1'b1) begin nMis++; $display("FAIL misal_sticky: got %b want 1", fetchErr); end
        nVec++; if (fetchCount !== 32'd6) begin nMis++; $display("FAIL misal_count: got %0d want 6", fetchCount); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        nVec++; if (fetchErr !== 1'b0) begin nMis++; $display("FAIL misal_rst_clear: got %b want 0", fetchErr); end
    endtask

    task automatic test_out_of_range();
        redirectValid = 1'b1;
        redirectPc    = 32'hF8;
        step();
        clear_inputs();
        step();
        step();
        nVec++; if (ifidPc !== 32'hFC) begin nMis++; $display("FAIL oor_last_pc: got %h want fc", ifidPc); end
        nVec++; if (ifidValid !== 1'b1) begin nMis++; $display("FAIL oor_last_valid: got %b want 1", ifidValid); end
        nVec++; if (ifidInstr !== 32'h440) begin nMis++; $display("FAIL oor_last_instr: got %h want 440", ifidInstr); end
        nVec++; if (fetchErr !== 1'b0) begin nMis++; $display("FAIL oor_last_err: got %b want 0", fetchErr); end
        nVec++; if (imemPc !== 32'h100) begin nMis++; $display("FAIL oor_next_pc: got %h want 100", imemPc); end
        step();
        step();
        nVec++; if (ifidValid !== 1'b0) begin nMis++; $display("FAIL oor_valid: got %b want 0", ifidValid); end
        nVec++; if (fetchErr !== 1'b1) begin nMis++; $display("FAIL oor_err: got %b want 1", fetchErr); end
        nVec++; if (imemPc !== 32'h100) begin nMis++; $display("FAIL oor_hold_pc: got %h want 100", imemPc); end
        nVec++; if (ifidPc !== 32'hFC) begin nMis++; $display("FAIL oor_hold_ifid: got %h want fc", ifidPc); end
        nVec++; if (fetchCount !== 32'd2) begin nMis++; $display("FAIL oor_count: got %0d want 2", fetchCount); end
        redirectValid = 1'b1;
        redirectPc    = 32'h0;
        step();
        clear_inputs();
        step();
        nVec++; if (ifidPc !== 32'h0) begin nMis++; $display("FAIL oor_resume_pc: got %h want 0", ifidPc); end
        nVec++; if (ifidValid !== 1'b1) begin nMis++; $display("FAIL oor_resume_valid: got %b want 1", ifidValid); end
        nVec++; if (ifidInstr !== 32'h11) begin nMis++; $display("FAIL oor_resume_instr: got %h want 11", ifidInstr); end
        nVec++; if (fetchCount !== 32'd3) begin nMis++; $display("FAIL oor_resume_count: got %0d want 3", fetchCount); end
    endtask

    task automatic test_reset_during_redirect();
        redirectValid = 1'b1;
        redirectPc    = 32'h80;
        stall         = 1'b1;
        rst           = 1'b1;
        step();
        clear_inputs();
        nVec++; if (imemPc !== 32'h0) begin nMis++; $display("FAIL rstred_pc: got %h want 0", imemPc); end
        nVec++; if (ifidValid !== 1'b0) begin nMis++; $display("FAIL rstred_valid: got %b want 0", ifidValid); end
        nVec++; if (ifidPc !== 32'h0) begin nMis++; $display("FAIL rstred_ifid_pc: got %h want 0", ifidPc); end
        nVec++; if (ifidPcPlus4 !== 32'h0) begin nMis++; $display("FAIL rstred_plus4: got %h want 0", ifidPcPlus4); end
        nVec++; if (ifidInstr !== 32'h0) begin nMis++; $display("FAIL rstred_instr: got %h want 0", ifidInstr); end
        nVec++; if (fetchErr !== 1'b0) begin nMis++; $display("FAIL rstred_err: got %b want 0", fetchErr); end
        nVec++; if (fetchCount !== 32'd0) begin nMis++; $display("FAIL rstred_count: got %0d want 0", fetchCount); end
    endtask

    initial begin
        nVec = 0;
        nMis = 0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall_flush();
        test_flush();
        test_misaligned();
        test_out_of_range();
        test_reset_during_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
